// File: rtl/seq_autocorr.sv
// Periodic autocorrelation of an N-bit binary sequence, one tau per N+1 cycles,
// results handed out over a valid/ready port. Optional peak tracking: SEQ_AUTOCORR_PEAK_EN.
module seq_autocorr #(
  parameter int N = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N-1:0]           seq_in,
  output logic                   busy,
  output logic                   corr_valid,
  input  logic                   corr_ready,
  output logic [$clog2(N)-1:0]   corr_shift,
  output logic [$clog2(N)+1:0]   corr_val,
  output logic                   done,
  output logic [$clog2(N)+1:0]   peak_mag,
  output logic [$clog2(N)-1:0]   peak_shift
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N) + 2;
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT, DONE} state_t;

  state_t state_q, state_d;

  logic [N-1:0]           ref_q;
  logic [N-1:0]           rot_q;
  logic [SW-1:0]          tau_q;
  logic [SW-1:0]          t_q;
  logic signed [CW-1:0]   acc_q;

  logic capture;
  logic step;
  logic advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    step    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        step = 1'b1;
        if (t_q == LAST) state_d = OUT;
      end
      OUT: begin
        if (corr_ready) begin
          if (tau_q != LAST) begin
            advance = 1'b1;
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rot_q always holds s rotated so that rot_q[t] = s((t+tau) mod N)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      rot_q <= '0;
      tau_q <= '0;
      t_q   <= '0;
      acc_q <= '0;
    end else if (capture) begin
      ref_q <= seq_in;
      rot_q <= seq_in;
      tau_q <= '0;
      t_q   <= '0;
      acc_q <= '0;
    end else if (step) begin
      t_q <= t_q + SW'(1);
      if (ref_q[t_q] == rot_q[t_q]) acc_q <= acc_q + CW'(1);
      else                          acc_q <= acc_q - CW'(1);
    end else if (advance) begin
      tau_q <= tau_q + SW'(1);
      rot_q <= {rot_q[0], rot_q[N-1:1]};
      t_q   <= '0;
      acc_q <= '0;
    end
  end

  assign busy       = (state_q != IDLE);
  assign corr_valid = (state_q == OUT);
  assign done       = (state_q == DONE);
  assign corr_shift = tau_q;
  assign corr_val   = acc_q;

`ifdef SEQ_AUTOCORR_PEAK_EN
  logic [CW-1:0] peak_mag_q;
  logic [SW-1:0] peak_shift_q;
  logic [CW-1:0] acc_abs;
  logic          handshake;

  assign handshake = (state_q == OUT) && corr_ready;
  assign acc_abs   = acc_q[CW-1] ? $unsigned(-acc_q) : $unsigned(acc_q);

  // Strictly-greater update keeps the earliest tau on ties; tau 0 is the trivial peak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_mag_q   <= '0;
      peak_shift_q <= '0;
    end else if (capture) begin
      peak_mag_q   <= '0;
      peak_shift_q <= '0;
    end else if (handshake && (tau_q != '0) && (acc_abs > peak_mag_q)) begin
      peak_mag_q   <= acc_abs;
      peak_shift_q <= tau_q;
    end
  end

  assign peak_mag   = peak_mag_q;
  assign peak_shift = peak_shift_q;
`else
  assign peak_mag   = '0;
  assign peak_shift = '0;
`endif

endmodule

// File: tb/tb_seq_autocorr.sv
// Directed bench for seq_autocorr: a scoreboard of model C(tau) values is loaded at start
// and drained as results are handed over; covers timing, stall, restart-ignore and reset.
module tb_seq_autocorr;

  localparam int N     = 23;
  localparam int SW    = $clog2(N);
  localparam int CW    = $clog2(N) + 2;
  localparam int LIMIT = N * (N + 1) + 100;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [N-1:0]         seq_in;
  logic                 busy;
  logic                 corr_valid;
  logic                 corr_ready;
  logic [SW-1:0]        corr_shift;
  logic signed [CW-1:0] corr_val;
  logic                 done;
  logic [CW-1:0]        peak_mag;
  logic [SW-1:0]        peak_shift;

  typedef struct {
    int shift;
    int val;
  } sb_t;

  sb_t          exp_q[$];
  int           vectors;
  int           miscompares;
  logic [N-1:0] cur_seq;

  seq_autocorr #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seq_in     (seq_in),
    .busy       (busy),
    .corr_valid (corr_valid),
    .corr_ready (corr_ready),
    .corr_shift (corr_shift),
    .corr_val   (corr_val),
    .done       (done),
    .peak_mag   (peak_mag),
    .peak_shift (peak_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_c(input logic [N-1:0] s, input int tau);
    int c;
    c = 0;
    for (int t = 0; t < N; t++) c += (s[t] == s[(t + tau) % N]) ? 1 : -1;
    return c;
  endfunction

  function automatic void model_peak(input logic [N-1:0] s, output int mag, output int sh);
    int a;
    mag = 0;
    sh  = 0;
    for (int tau = 1; tau < N; tau++) begin
      a = model_c(s, tau);
      if (a < 0) a = -a;
      if (a > mag) begin
        mag = a;
        sh  = tau;
      end
    end
  endfunction

  function automatic logic [N-1:0] legendre_seq();
    logic [N-1:0] s;
    s = '0;
    for (int t = 1; t < N; t++)
      for (int x = 1; x < N; x++)
        if ((x * x) % N == t) s[t] = 1'b1;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checkOutput({tag, "_busy"},       busy,       0);
    checkOutput({tag, "_valid"},      corr_valid, 0);
    checkOutput({tag, "_done"},       done,       0);
    checkOutput({tag, "_shift"},      corr_shift, 0);
    checkOutput({tag, "_val"},        corr_val,   0);
    checkOutput({tag, "_peak_mag"},   peak_mag,   0);
    checkOutput({tag, "_peak_shift"}, peak_shift, 0);
  endtask

  task automatic applyStimulus(input logic [N-1:0] s);
    sb_t e;
    @(negedge clk);
    seq_in  = s;
    start   = 1'b1;
    cur_seq = s;
    for (int tau = 0; tau < N; tau++) begin
      e.shift = tau;
      e.val   = model_c(s, tau);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pop_compare();
    sb_t e;
    if (exp_q.size() == 0) begin
      checkOutput("sb_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("result_shift", corr_shift, e.shift);
      checkOutput("result_val",   corr_val,   e.val);
    end
  endtask

  // k counts rising edges after the one that sampled start; outputs are read 1ns after each
  task automatic run_to_done(input int stall_tau, input int stall_len, input bit intrude,
                             input int exp_done);
    int first_valid;
    int done_at;
    int stalled;
    int pmag;
    int pshift;
    first_valid = -1;
    done_at     = -1;
    stalled     = 0;
    corr_ready  = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) checkOutput("busy_after_start", busy, 1);
      if (intrude && k == 5) begin
        start  = 1'b1;
        seq_in = ~seq_in;
      end else if (intrude && k == 6) begin
        start = 1'b0;
      end
      if (corr_valid && first_valid < 0) first_valid = k;
      if (done) begin
        done_at = k;
        break;
      end
      if (stalled > 0 && stalled <= stall_len) begin
        checkOutput("stall_valid", corr_valid, 1);
        checkOutput("stall_shift", corr_shift, stall_tau);
        if (exp_q.size() > 0) checkOutput("stall_val", corr_val, exp_q[0].val);
        stalled++;
        if (stalled > stall_len) begin
          corr_ready = 1'b1;
          pop_compare();
        end
      end else if (corr_valid) begin
        if (stall_len > 0 && stalled == 0 && int'(corr_shift) == stall_tau) begin
          corr_ready = 1'b0;
          stalled    = 1;
        end else begin
          pop_compare();
        end
      end
    end
    checkOutput("valid_latency", first_valid, N);
    checkOutput("done_cycle", done_at, exp_done);
    checkOutput("sb_drained", exp_q.size(), 0);
`ifdef SEQ_AUTOCORR_PEAK_EN
    model_peak(cur_seq, pmag, pshift);
`else
    pmag   = 0;
    pshift = 0;
`endif
    checkOutput("peak_mag", peak_mag, pmag);
    checkOutput("peak_shift", peak_shift, pshift);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    corr_ready  = 1'b0;
    seq_in      = '0;
    cur_seq     = '0;
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] all-zero sequence");
    applyStimulus('0);
    run_to_done(-1, 0, 1'b0, N * (N + 1));

    $display("[TB] single-one sequence");
    applyStimulus(23'h000001);
    run_to_done(-1, 0, 1'b0, N * (N + 1));
`ifdef SEQ_AUTOCORR_PEAK_EN
    checkOutput("seq1_peak_mag", peak_mag, 19);
    checkOutput("seq1_peak_shift", peak_shift, 1);
`endif

    $display("[TB] random sequence with a 10-cycle stall at tau 3");
    applyStimulus(N'($urandom()));
    run_to_done(3, 10, 1'b0, N * (N + 1) + 10);

    $display("[TB] start pulse while busy");
    applyStimulus(23'h5A3C1);
    run_to_done(-1, 0, 1'b1, N * (N + 1));

    $display("[TB] reset during accumulation of tau 5");
    applyStimulus(23'h3F00A5);
    corr_ready = 1'b1;
    repeat (5 * (N + 1) + 3) @(posedge clk);
    #1;
    checkOutput("pre_reset_shift", corr_shift, 5);
    checkOutput("pre_reset_valid", corr_valid, 0);
    rst_n = 1'b0;
    #2;
    check_idle_zero("midrun_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] Legendre sequence after reset");
    applyStimulus(legendre_seq());
    run_to_done(-1, 0, 1'b0, N * (N + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
